// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end fetch stage of the 16-bit CPU. Owns the PC, fetches each
// big-endian instruction as two byte reads ({mem[pc], mem[pc+1]}) over a
// byte-wide req/gnt/rvalid port, and hands the assembled word to decode
// through a valid/ready handshake. Downstream redirects (branch/jump)
// override sequential pc+2 fetch and have priority in every state.
//
// Parameters
//   RESET_PC       PC loaded on reset (first instruction address)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   o_mem_req      byte read request, held until i_mem_gnt
//   o_mem_addr     byte address, stable while o_mem_req=1
//   i_mem_gnt      request accepted this cycle
//   i_mem_rvalid   read byte valid (earliest the cycle after the grant)
//   i_mem_rdata    read byte
//   o_instr_valid  o_instr / o_instr_pc valid for downstream
//   i_instr_ready  downstream accepts the instruction
//   o_instr        assembled instruction {hi_byte, lo_byte}
//   o_instr_pc     address of o_instr (hi byte address)
//   i_redirect     one-cycle request to restart fetch at i_redirect_pc
//   i_redirect_pc  redirect target
//   o_misalign     one-cycle pulse: an odd redirect target was forced even
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'd10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_misalign
);

    typedef enum logic [2:0] {
        StReqHi,
        StWaitHi,
        StReqLo,
        StWaitLo,
        StValid,
        StDrain
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_hi;
    logic        r_instr_valid;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_misalign;

    logic        w_mem_hs;
    logic [15:0] w_target;
    logic [15:0] w_pc_plus1;
    logic [15:0] w_pc_plus2;

    // A handshake only exists while a request is actually being presented;
    // right after reset the FSM sits in StReqHi with o_mem_req still low.
    assign w_mem_hs   = r_mem_req & i_mem_gnt;
    // Instructions are 2-byte aligned, so the target LSB is simply dropped.
    assign w_target   = {i_redirect_pc[15:1], 1'b0};
    assign w_pc_plus1 = r_pc + 16'd1;
    assign w_pc_plus2 = r_pc + 16'd2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StReqHi;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_hi          <= 8'h00;
            r_instr_valid <= 1'b0;
            r_instr       <= 16'h0000;
            r_instr_pc    <= RESET_PC;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (i_redirect) begin
                r_pc          <= w_target;
                r_misalign    <= i_redirect_pc[0];
                r_instr_valid <= 1'b0;
                case (r_state)
                    StReqHi, StReqLo: begin
                        if (w_mem_hs) begin
                            // Request already accepted: its byte must be absorbed.
                            r_state   <= StDrain;
                            r_mem_req <= 1'b0;
                        end else begin
                            // No handshake yet, so the request can be withdrawn.
                            r_state    <= StReqHi;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_target;
                        end
                    end
                    StWaitHi, StWaitLo, StDrain: begin
                        if (i_mem_rvalid) begin
                            // In-flight byte lands now and is dropped.
                            r_state    <= StReqHi;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_target;
                        end else begin
                            r_state   <= StDrain;
                            r_mem_req <= 1'b0;
                        end
                    end
                    default: begin
                        // StValid: a simultaneous ready consumes the word, but the
                        // redirect target still wins over pc+2.
                        r_state    <= StReqHi;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_target;
                    end
                endcase
            end else begin
                case (r_state)
                    StReqHi: begin
                        if (w_mem_hs) begin
                            r_state   <= StWaitHi;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
                    end
                    StWaitHi: begin
                        if (i_mem_rvalid) begin
                            r_hi       <= i_mem_rdata;
                            r_state    <= StReqLo;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_pc_plus1;
                        end
                    end
                    StReqLo: begin
                        if (w_mem_hs) begin
                            r_state   <= StWaitLo;
                            r_mem_req <= 1'b0;
                        end
                    end
                    StWaitLo: begin
                        if (i_mem_rvalid) begin
                            r_instr       <= {r_hi, i_mem_rdata};
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= StValid;
                        end
                    end
                    StValid: begin
                        // Back-pressure: nothing is requested until downstream takes it.
                        if (i_instr_ready) begin
                            r_instr_valid <= 1'b0;
                            r_pc          <= w_pc_plus2;
                            r_state       <= StReqHi;
                            r_mem_req     <= 1'b1;
                            r_mem_addr    <= w_pc_plus2;
                        end
                    end
                    StDrain: begin
                        // pc already holds the redirect target.
                        if (i_mem_rvalid) begin
                            r_state    <= StReqHi;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
                    end
                    default: begin
                        r_state   <= StReqHi;
                        r_mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_instr_valid = r_instr_valid;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A byte memory model answers requests
// (grant stalls, delayed rvalid and redirect triggers are set per address),
// expected fetch addresses and instructions are queued as each step is set
// up and popped whenever the DUT completes a memory or instruction handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        misalign;

    instr_fetch_unit #(
        .RESET_PC(16'd10)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .o_instr      (instr),
        .o_instr_pc   (instr_pc),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q[$];
    logic [15:0] addr_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // memory model / stimulus knobs
    logic        ready_v      = 1'b1;
    logic        redir_now    = 1'b0;
    logic [15:0] redir_tgt    = 16'h0;
    logic        redir_arm    = 1'b0;
    logic [15:0] redir_arm_at = 16'h0;
    logic [15:0] redir_arm_tgt = 16'h0;
    logic        fire_redir   = 1'b0;
    logic [15:0] delay_addr   = 16'h0;
    int          delay_cnt    = 0;
    logic        rvx_en       = 1'b0;
    logic [15:0] rvx_addr     = 16'h0;
    int          resp_cnt     = 0;
    logic [15:0] resp_addr    = 16'h0;
    logic        gnt_now      = 1'b0;
    logic [15:0] gnt_addr_now = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_instr(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = {mem[pc], mem[pc + 16'd1]};
        exp_q.push_back(e);
    endtask

    // One clock cycle: at the falling edge look at DUT outputs, drive this
    // cycle's inputs and score any handshake that the next rising edge takes.
    task tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        if (redir_now) begin
            redirect    = 1'b1;
            redirect_pc = redir_tgt;
            redir_now   = 1'b0;
        end else if (fire_redir) begin
            redirect    = 1'b1;
            redirect_pc = redir_arm_tgt;
        end
        fire_redir = 1'b0;

        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        if (resp_cnt == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[resp_addr];
        end
        if (resp_cnt > 0) resp_cnt--;

        mem_gnt = 1'b0;
        gnt_now = 1'b0;
        if (mem_req) begin
            if (delay_cnt > 0 && mem_addr == delay_addr) begin
                delay_cnt--;
            end else begin
                mem_gnt      = 1'b1;
                gnt_now      = 1'b1;
                gnt_addr_now = mem_addr;
                check("one_outstanding", resp_cnt, 0);
                if (rvx_en && mem_addr == rvx_addr) begin
                    resp_cnt = 2;
                    rvx_en   = 1'b0;
                end else begin
                    resp_cnt = 1;
                end
                resp_addr = mem_addr;
                if (redir_arm && mem_addr == redir_arm_at) begin
                    fire_redir = 1'b1;
                    redir_arm  = 1'b0;
                end
                check("req_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) check("mem_addr_hs", mem_addr, addr_q.pop_front());
            end
        end

        instr_ready = ready_v;
        if (instr_valid && ready_v) begin
            check("instr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr", instr, e.word);
                check("instr_pc", instr_pc, e.pc);
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!instr_valid && k < 100);
        check(tag, 32'(instr_valid), 1);
    endtask

    task automatic wait_consumed(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (exp_q.size() != 0 && k < 200);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 0);
        check({tag, "_mem_addr"}, mem_addr, 16'd10);
        check({tag, "_instr_valid"}, 32'(instr_valid), 0);
        check({tag, "_instr"}, instr, 16'h0000);
        check({tag, "_instr_pc"}, instr_pc, 16'd10);
        check({tag, "_misalign"}, 32'(misalign), 0);
    endtask

    initial begin
        int t0;
        int t1;
        int k;

        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 8));
        mem[10] = 8'h91;
        mem[11] = 8'h05;

        rst_n       = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 8'h00;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");

        // 1: first instruction from RESET_PC, 4-cycle latency, then 12/13
        addr_q.push_back(16'd10);
        addr_q.push_back(16'd11);
        addr_q.push_back(16'd12);
        addr_q.push_back(16'd13);
        push_instr(16'd10);
        push_instr(16'd12);
        ready_v = 1'b1;
        rst_n   = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!mem_req && k < 20);
        check("first_req", 32'(mem_req), 1);
        t0 = cyc;
        wait_valid("first_valid");
        t1 = cyc;
        check("first_latency", t1 - t0, 4);
        check("first_word", instr, 16'h9105);
        ready_v = 1'b0;

        // 2: back-pressure for 3 cycles on the instruction at 12
        wait_valid("bp_valid");
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            check("bp_instr", instr, {mem[12], mem[13]});
            check("bp_instr_pc", instr_pc, 16'd12);
            check("bp_mem_req", 32'(mem_req), 0);
            check("bp_instr_valid", 32'(instr_valid), 1);
        end
        addr_q.push_back(16'd14);
        addr_q.push_back(16'd15);
        push_instr(16'd14);
        ready_v = 1'b1;
        tick();

        // 3: lo-byte grant withheld for 3 cycles at address 15
        delay_addr = 16'd15;
        delay_cnt  = 3;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(mem_req && mem_addr[0]) && k < 20);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            check("stall_mem_req", 32'(mem_req), 1);
            check("stall_mem_addr", mem_addr, 16'd15);
            check("stall_no_gnt", 32'(gnt_now), 0);
        end
        wait_consumed("stall_done");

        // 4: redirect to 0x0020 while waiting for the lo byte of 17
        addr_q.push_back(16'd16);
        addr_q.push_back(16'd17);
        addr_q.push_back(16'h0020);
        addr_q.push_back(16'h0021);
        push_instr(16'h0020);
        rvx_en        = 1'b1;
        rvx_addr      = 16'd17;
        redir_arm     = 1'b1;
        redir_arm_at  = 16'd17;
        redir_arm_tgt = 16'h0020;
        wait_consumed("drain_done");

        // 5: odd redirect target 0x0015, lands on a granted request at 0x22
        addr_q.push_back(16'h0022);
        addr_q.push_back(16'h0014);
        addr_q.push_back(16'h0015);
        push_instr(16'h0014);
        redir_now = 1'b1;
        redir_tgt = 16'h0015;
        tick();
        check("misalign_before", 32'(misalign), 0);
        tick();
        check("misalign_pulse", 32'(misalign), 1);
        check("misalign_drops_valid", 32'(instr_valid), 0);
        tick();
        check("misalign_after", 32'(misalign), 0);
        wait_consumed("misalign_done");

        // 6: wrap at 0xFFFE, then reset while waiting for the hi byte at 0x0000
        addr_q.push_back(16'h0016);
        addr_q.push_back(16'hFFFE);
        addr_q.push_back(16'hFFFF);
        addr_q.push_back(16'h0000);
        push_instr(16'hFFFE);
        redir_now = 1'b1;
        redir_tgt = 16'hFFFE;
        rvx_en    = 1'b1;
        rvx_addr  = 16'h0000;
        wait_consumed("wrap_done");
        k = 0;
        do begin
            tick();
            k++;
        end while (!(gnt_now && gnt_addr_now == 16'h0000) && k < 20);
        check("wrap_pc", gnt_addr_now, 16'h0000);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        addr_q.push_back(16'd10);
        addr_q.push_back(16'd11);
        push_instr(16'd10);
        #2;
        rst_n = 1'b1;
        wait_consumed("restart_done");

        check("addr_q_empty", addr_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case the DUT deadlocks somewhere the bounded waits miss.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
